// File: rtl/mem_fill_if.sv
// Bundle for mem_fill_engine: job request (start/abort/mode/range/pattern), job status
// (busy/done) and the Avalon-style burst write port (mem_*). Wires only; no logic or latency.
// Backpressure is mem_busy (waitrequest), which the slave drives and the engine honours.
// Ports: master = engine side (drives mem_*, busy, done); slave = requester/memory side.
interface mem_fill_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
);
    logic                  start;
    logic                  abort;
    logic [1:0]            mode;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     length;
    logic [DATA_W-1:0]     pattern;
    logic                  mem_busy;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_din;
    logic [7:0]            mem_burstcnt;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, mode, base_addr, length, pattern, mem_busy,
        output mem_we, mem_addr, mem_din, mem_burstcnt, mem_be, busy, done
    );

    modport slave (
        output start, abort, mode, base_addr, length, pattern, mem_busy,
        input  mem_we, mem_addr, mem_din, mem_burstcnt, mem_be, busy, done
    );
endinterface

// File: rtl/mem_fill_engine.sv
// RAM clear/fill sequencer: writes a rounded address range in BURST-word bursts with a pattern.
// Latency: first mem_we one cycle after an accepted start; one beat per cycle when not stalled.
// Backpressure: mem_busy holds the current beat (address and data frozen) until it drops.
// Ports: clk_sys, RESET (sync, active-low), bus (mem_fill_if.master: job control, status, write port).
module mem_fill_engine #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64,
    parameter int BURST  = 8,
    parameter int GAP    = 24
) (
    input  logic       clk_sys,
    input  logic       RESET,
    mem_fill_if.master bus
);
    localparam int                GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
    localparam logic [7:0]        BEAT_LAST = 8'(BURST - 1);
    localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_seen_q, abort_seen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remain_q, remain_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   pattern_q, pattern_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [31:0]         lfsr_q, lfsr_d;

    logic [ADDR_W-1:0]   len_rnd;
    logic [ADDR_W-1:0]   remain_nxt;
    logic [ADDR_W-1:0]   idx_nxt;
    logic [31:0]         seed;
    logic [31:0]         lfsr_nxt;
    logic                accept;

    // Galois form, shifting right: the bit falling out of bit 0 folds the taps back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] beat_data(input logic [1:0]        m,
                                                    input logic [DATA_W-1:0] pat,
                                                    input logic [ADDR_W-1:0] i,
                                                    input logic [31:0]       l);
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = '0;
            2'd1:    r = pat;
            2'd2:    r = DATA_W'(i);
            default: r = {(DATA_W/32){l}};
        endcase
        return r;
    endfunction

    assign len_rnd    = bus.length - (bus.length % BURST_A);
    assign seed       = (bus.pattern[31:0] == 32'd0) ? 32'd1 : bus.pattern[31:0];
    assign accept     = we_q && !bus.mem_busy;
    assign lfsr_nxt   = lfsr_step(lfsr_q);
    assign idx_nxt    = idx_q + 1'b1;
    assign remain_nxt = remain_q - BURST_A;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        busy_d       = busy_q;
        done_d       = done_q;
        abort_seen_d = abort_seen_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        idx_d        = idx_q;
        beat_d       = beat_q;
        gap_d        = gap_q;
        mode_d       = mode_q;
        pattern_d    = pattern_q;
        din_d        = din_q;
        lfsr_d       = lfsr_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d       = 1'b0;
                    mode_d       = bus.mode;
                    pattern_d    = bus.pattern;
                    addr_d       = bus.base_addr;
                    remain_d     = len_rnd;
                    idx_d        = '0;
                    beat_d       = '0;
                    gap_d        = '0;
                    abort_seen_d = 1'b0;
                    lfsr_d       = seed;
                    // Beat 0 data is registered here so it is on the bus with the first mem_we.
                    din_d        = beat_data(bus.mode, bus.pattern, '0, seed);
                    if (len_rnd == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (bus.abort) abort_seen_d = 1'b1;
                if (accept) begin
                    idx_d  = idx_nxt;
                    lfsr_d = lfsr_nxt;
                    din_d  = beat_data(mode_q, pattern_q, idx_nxt, lfsr_nxt);
                    if (beat_q == BEAT_LAST) begin
                        beat_d       = '0;
                        addr_d       = addr_q + BURST_A;
                        remain_d     = remain_nxt;
                        abort_seen_d = 1'b0;
                        // Completion is checked first so a same-cycle abort still reports done.
                        if (remain_nxt == '0) begin
                            state_d = IDLE;
                            we_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (abort_seen_q || bus.abort) begin
                            state_d = IDLE;
                            we_d    = 1'b0;
                            busy_d  = 1'b0;
                        end else if (GAP > 0) begin
                            state_d = PAUSE;
                            we_d    = 1'b0;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            PAUSE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_seen_q <= 1'b0;
            addr_q       <= '0;
            remain_q     <= '0;
            idx_q        <= '0;
            beat_q       <= '0;
            gap_q        <= '0;
            mode_q       <= '0;
            pattern_q    <= '0;
            din_q        <= '0;
            lfsr_q       <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_seen_q <= abort_seen_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            idx_q        <= idx_d;
            beat_q       <= beat_d;
            gap_q        <= gap_d;
            mode_q       <= mode_d;
            pattern_q    <= pattern_d;
            din_q        <= din_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_din      = din_q;
    assign bus.mem_burstcnt = 8'(BURST);
    assign bus.mem_be       = '1;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_mem_fill_engine.sv
// Bench for mem_fill_engine: two instances (A: BURST 8, no gap, no backpressure;
// B: BURST 4, GAP 4, random backpressure). Expected beats come from a range/pattern model
// pushed at job start; negedge monitors pop and compare every accepted beat.
module tb_mem_fill_engine;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int BA = 8;
    localparam int GA = 0;
    localparam int BB = 4;
    localparam int GB = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic clk_sys = 1'b0;
    logic RESET;
    always #5 clk_sys = ~clk_sys;

    logic          start_a, start_b, abort_a, abort_b, mbusy_b, bp_en;
    logic [1:0]    mode_v;
    logic [AW-1:0] base_v, len_v;
    logic [DW-1:0] pat_v;

    mem_fill_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_fill_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.start     = start_a;
    assign ifa.abort     = abort_a;
    assign ifa.mode      = mode_v;
    assign ifa.base_addr = base_v;
    assign ifa.length    = len_v;
    assign ifa.pattern   = pat_v;
    assign ifa.mem_busy  = 1'b0;
    assign ifb.start     = start_b;
    assign ifb.abort     = abort_b;
    assign ifb.mode      = mode_v;
    assign ifb.base_addr = base_v;
    assign ifb.length    = len_v;
    assign ifb.pattern   = pat_v;
    assign ifb.mem_busy  = mbusy_b;

    mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .BURST(BA), .GAP(GA)) dut_a (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (ifa)
    );
    mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .BURST(BB), .GAP(GB)) dut_b (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (ifb)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t qa[$];
    beat_t qb[$];
    int    acc_a = 0, acc_b = 0, bcyc_a = 0, idle_b = 0;
    logic          stall_b = 1'b0;
    logic [DW-1:0] held_din;
    logic [AW-1:0] held_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Whole job as the list of beats the memory should see, in order.
    task automatic push_job(input int w, input int bst, input logic [AW-1:0] base, input int len,
                            input logic [1:0] mode, input logic [DW-1:0] pat, output int n);
        beat_t       b;
        logic [31:0] l;
        n = (len / bst) * bst;
        l = (pat[31:0] == 32'd0) ? 32'd1 : pat[31:0];
        for (int i = 0; i < n; i++) begin
            b.addr = AW'(int'(base) + (i / bst) * bst);
            case (mode)
                2'd0:    b.data = '0;
                2'd1:    b.data = pat;
                2'd2:    b.data = DW'(i);
                default: b.data = {2{l}};
            endcase
            l = lfsr_next(l);
            if (w == 0) qa.push_back(b); else qb.push_back(b);
        end
    endtask

    function automatic int acc_of(input int w);
        return (w == 0) ? acc_a : acc_b;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? ifa.done : ifb.done;
    endfunction
    function automatic logic we_of(input int w);
        return (w == 0) ? ifa.mem_we : ifb.mem_we;
    endfunction
    function automatic int qsize(input int w);
        return (w == 0) ? qa.size() : qb.size();
    endfunction

    always @(negedge clk_sys) begin : mon_a
        beat_t e;
        if (RESET === 1'b1) begin
            if (ifa.busy) bcyc_a++;
            if (ifa.mem_we && !ifa.mem_busy) begin
                acc_a++;
                if (qa.size() == 0) begin
                    flag("a_extra_beat", $sformatf("unexpected beat at addr 0x%0h", ifa.mem_addr));
                end else begin
                    e = qa.pop_front();
                    chk("a_addr", 64'(ifa.mem_addr), 64'(e.addr));
                    chk("a_data", ifa.mem_din, e.data);
                end
            end
        end
    end

    always @(negedge clk_sys) begin : mon_b
        beat_t e;
        if (RESET === 1'b1) begin
            if (stall_b && ifb.mem_we) begin
                chk("b_hold_data", ifb.mem_din, held_din);
                chk("b_hold_addr", 64'(ifb.mem_addr), 64'(held_addr));
            end
            stall_b   = ifb.mem_we && ifb.mem_busy;
            held_din  = ifb.mem_din;
            held_addr = ifb.mem_addr;
            if (ifb.busy && !ifb.mem_we) begin
                idle_b++;
            end else begin
                if (ifb.mem_we && idle_b > 0) chk("b_gap", 64'(idle_b), 64'(GB));
                idle_b = 0;
            end
            if (ifb.mem_we && !ifb.mem_busy) begin
                acc_b++;
                if (qb.size() == 0) begin
                    flag("b_extra_beat", $sformatf("unexpected beat at addr 0x%0h", ifb.mem_addr));
                end else begin
                    e = qb.pop_front();
                    chk("b_addr", 64'(ifb.mem_addr), 64'(e.addr));
                    chk("b_data", ifb.mem_din, e.data);
                end
            end
        end else begin
            stall_b = 1'b0;
            idle_b  = 0;
        end
    end

    initial begin
        mbusy_b = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            mbusy_b = bp_en && ($urandom_range(0, 3) == 0);
        end
    end

    // abort_at: -1 none; >=0 abort mid-burst once that many beats are in; -2 abort during a pause.
    // poke: issue an extra start with different inputs while the job is busy.
    task automatic run_job(input int w, input logic [AW-1:0] base, input int len,
                           input logic [1:0] mode, input logic [DW-1:0] pat,
                           input int abort_at, input bit poke);
        int    n, k, keep, acc0, bst;
        bit    aborted;
        string tg;
        tg   = (w == 0) ? "a" : "b";
        bst  = (w == 0) ? BA : BB;
        push_job(w, bst, base, len, mode, pat, n);
        keep    = n;
        aborted = 1'b0;
        acc0    = acc_of(w);
        bcyc_a  = 0;
        base_v  = base;
        len_v   = AW'(len);
        mode_v  = mode;
        pat_v   = pat;
        if (w == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk_sys); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (n == 0) begin
            chk({tg, "_zero_len_done"}, 64'(done_of(w)), 64'd1);
            chk({tg, "_zero_len_busy"}, 64'(busy_of(w)), 64'd0);
        end
        for (int t = 0; t < 4000 && busy_of(w); t++) begin
            k = acc_of(w) - acc0;
            if (poke && t == 2) begin
                base_v = ~base;
                len_v  = AW'(len + 4 * bst);
                if (w == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (!aborted && ((abort_at >= 0 && k >= abort_at && (k % bst) != 0) ||
                             (abort_at == -2 && k > 0 && !we_of(w)))) begin
                aborted = 1'b1;
                keep = (abort_at == -2) ? k : ((k / bst) + 1) * bst;
                if (keep > n) keep = n;
                if (w == 0) begin
                    abort_a = 1'b1;
                    while (qa.size() > keep - k) void'(qa.pop_back());
                end else begin
                    abort_b = 1'b1;
                    while (qb.size() > keep - k) void'(qb.pop_back());
                end
            end
            @(posedge clk_sys); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            abort_a = 1'b0;
            abort_b = 1'b0;
        end
        if (busy_of(w)) flag({tg, "_timeout"}, "busy never dropped");
        chk({tg, "_done"}, 64'(done_of(w)), (keep == n) ? 64'd1 : 64'd0);
        chk({tg, "_beats"}, 64'(acc_of(w) - acc0), 64'(keep));
        if (w == 0 && !aborted && n > 0) chk("a_busy_cycles", 64'(bcyc_a), 64'(n));
        repeat (3) @(posedge clk_sys);
        #1;
        chk({tg, "_no_beats_after"}, 64'(acc_of(w) - acc0), 64'(keep));
        chk({tg, "_queue_empty"}, 64'(qsize(w)), 64'd0);
    endtask

    task automatic reset_test();
        int n, a0, b0;
        push_job(0, BA, 12'h040, 64, 2'd2, '0, n);
        push_job(1, BB, 12'h040, 64, 2'd2, '0, n);
        base_v  = 12'h040;
        len_v   = 12'd64;
        mode_v  = 2'd2;
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk_sys); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        @(posedge clk_sys); #1;
        RESET = 1'b1;
        chk("rst_a_we", 64'(ifa.mem_we), 64'd0);
        chk("rst_a_busy", 64'(ifa.busy), 64'd0);
        chk("rst_a_done", 64'(ifa.done), 64'd0);
        chk("rst_a_addr", 64'(ifa.mem_addr), 64'd0);
        chk("rst_b_we", 64'(ifb.mem_we), 64'd0);
        chk("rst_b_busy", 64'(ifb.busy), 64'd0);
        qa.delete();
        qb.delete();
        a0 = acc_a;
        b0 = acc_b;
        repeat (6) @(posedge clk_sys);
        #1;
        chk("rst_a_no_beats", 64'(acc_a - a0), 64'd0);
        chk("rst_b_no_beats", 64'(acc_b - b0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            w, len, ab;
        logic [DW-1:0] pat;
        RESET   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        abort_a = 1'b0;
        abort_b = 1'b0;
        bp_en   = 1'b0;
        mode_v  = 2'd0;
        base_v  = '0;
        len_v   = '0;
        pat_v   = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("init_a_we", 64'(ifa.mem_we), 64'd0);
        chk("init_a_addr", 64'(ifa.mem_addr), 64'd0);
        chk("init_a_din", ifa.mem_din, 64'd0);
        chk("init_a_busy", 64'(ifa.busy), 64'd0);
        chk("init_a_done", 64'(ifa.done), 64'd0);
        chk("init_b_we", 64'(ifb.mem_we), 64'd0);
        chk("init_b_burstcnt", 64'(ifb.mem_burstcnt), 64'(BB));
        chk("init_a_be", 64'(ifa.mem_be), 64'hFF);
        RESET = 1'b1;

        run_job(0, 12'h100, 32, 2'd0, '0, -1, 1'b0);
        run_job(0, 12'h200, 0, 2'd1, 64'hDEAD, -1, 1'b0);
        run_job(0, 12'h200, 13, 2'd1, 64'h0123_4567_89AB_CDEF, -1, 1'b0);

        fork
            run_job(0, 12'hFF8, 16, 2'd3, '0, -1, 1'b0);
            begin
                @(posedge clk_sys); #2;
                chk("wrap_beat0_data", ifa.mem_din, 64'h00000001_00000001);
                chk("wrap_beat0_addr", 64'(ifa.mem_addr), 64'hFF8);
                @(posedge clk_sys); #2;
                chk("wrap_beat1_data", ifa.mem_din, 64'h80200003_80200003);
                repeat (7) @(posedge clk_sys);
                #2;
                chk("wrap_burst2_addr", 64'(ifa.mem_addr), 64'h000);
            end
        join

        bp_en = 1'b1;
        run_job(1, 12'h300, 16, 2'd2, '0, -1, 1'b0);
        run_job(1, 12'h400, 16, 2'd1, 64'hA5A5_5A5A_F00D_BEEF, 2, 1'b1);
        run_job(1, 12'h400, 16, 2'd1, 64'hA5A5_5A5A_F00D_BEEF, -1, 1'b0);
        run_job(1, 12'h500, 24, 2'd2, '0, -2, 1'b0);
        run_job(1, 12'hFFC, 8, 2'd3, 64'h0000_0000_1234_5678, -1, 1'b0);

        reset_test();

        for (int j = 0; j < 30; j++) begin
            w   = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 40));
            pat = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pat[31:0] = 32'd0;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_job(w, AW'($urandom), len, 2'($urandom_range(0, 3)), pat, ab, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_fill_engine.md
Name: mem_fill_engine

Overview:
- Parametrised RAM clear/fill sequencer for utility cores; successor to the free-running clear counter.
- Writes a programmed address range of SDRAM/DDR3 through an Avalon-style burst write port, one range per start request.
- Selectable fill pattern, burst length and inter-burst pacing.
- Reports busy/done so HPS-side logic knows when RAM is clean before launching a core.

Parameters:
ADDR_W, 29, word address width of the memory port
DATA_W, 64, data width; multiple of 32
BURST, 8, words per burst (1..255)
GAP, 24, idle cycles inserted after each completed burst (0 = back-to-back)

Ports:
clk_sys  in  1  system clock
RESET  in  1  synchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  stop request; honoured at the next burst boundary
mode  in  2  0 zero, 1 constant, 2 incrementing, 3 LFSR
base_addr  in  ADDR_W  first word address
length  in  ADDR_W  words to write; low bits below BURST granularity ignored (rounded down to a BURST multiple)
pattern  in  DATA_W  constant value (mode 1) / LFSR seed from bits [31:0] (mode 3)
mem_busy  in  1  slave waitrequest
mem_we  out  1  write beat valid
mem_addr  out  ADDR_W  burst start address
mem_din  out  DATA_W  write data
mem_burstcnt  out  8  always BURST
mem_be  out  DATA_W/8  all ones
busy  out  1  high from accepted start until return to IDLE
done  out  1  sticky; set on normal completion, cleared by next accepted start

Behaviour:
- Reset (RESET=0 at edge): state IDLE; mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, internal counters 0. Applies mid-burst; the slave sees the burst truncated (accepted).
- States: IDLE, WRITE, PAUSE.
- IDLE:
  - On start=1, latch base_addr, rounded length, mode, pattern; clear done.
  - Rounded length 0: stay IDLE and set done on the next edge. No writes issued; busy stays 0.
  - Otherwise set busy=1 and enter WRITE; mem_we=1 on the next cycle.
  - abort is ignored in IDLE.
- WRITE:
  - mem_we=1. mem_addr holds the current burst start for the whole burst.
  - A beat is accepted on any edge with mem_we=1 and mem_busy=0.
  - mem_din changes only after an accepted beat; it is held while mem_busy=1.
  - After the BURST-th accepted beat, mem_addr advances by BURST, wrapping modulo 2^ADDR_W.
  - At that point the remaining-word count decrements by BURST, then:
    - count reaches 0: go IDLE, busy=0, done=1.
    - abort seen at any time during the burst (sticky flag): go IDLE, busy=0, done stays 0.
    - otherwise: go PAUSE if GAP>0, else start the next burst with no bubble.
- PAUSE: mem_we=0 for exactly GAP cycles, then WRITE. abort in PAUSE: go IDLE on the next edge, done=0.
- start while busy is ignored.
- Last beat and abort accepted together: completion wins, done=1.
- Data per accepted beat (index i counts from 0 within the job):
  - mode 0: all zero.
  - mode 1: pattern.
  - mode 2: i zero-extended to DATA_W.
  - mode 3: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (taps 0x80200003), replicated DATA_W/32 times.
    - Seed = pattern[31:0], or 1 if that is zero. Beat 0 carries the seed.
    - Advances one step per accepted beat.
- Throughput: GAP=0 and mem_busy=0 give one word per cycle. Latency from start to first mem_we is 1 cycle.

Test Plan:
- Reset: RESET=0 mid-burst, then RESET=1 -> next edge mem_we=0, busy=0, done=0, mem_addr=0; no further beats.
- Basic clear: BURST=8, GAP=0, mode 0, base=0x100, length=32, mem_busy=0 -> 32 zero beats on consecutive cycles; mem_addr 0x100/0x108/0x110/0x118; busy high 32 cycles; done=1.
- Backpressure and pacing: GAP=4, mode 2, mem_busy high on beats 3 and 9 for 2 cycles each, length=16 -> data 0..15 in order, each held while stalled; exactly 4 idle cycles after each burst.
- Edge lengths: length=0 -> done=1 next cycle, no mem_we, busy=0. length=13 with BURST=8 -> exactly 8 beats.
- Wrap and LFSR: ADDR_W=12, base=0xFF8, length=16, mode 3, pattern=0 -> bursts at 0xFF8 then 0x000; beat 0 data 0x00000001 replicated, beat 1 0x80200003 replicated.
- Abort and restart: abort pulse mid first burst of 4 -> burst completes, then IDLE with done=0; start during busy ignored; start after IDLE runs the full job and sets done=1.
